axi_wr_slave: RTL

- AXI write-channel slave front-end of the DDR2 controller; sits directly downstream of the AXI master and upstream of the DDR2 command/datapath engine.
- Accepts one AW request and its W burst into an internal burst buffer, then hands a single write command to the DDR2 engine.
- Supplies buffered beats on demand and returns the B response once the engine reports completion.
- One burst in flight; no write interleaving.

---
 rtl/axi_wr_slave_pkg.sv | 24 ++
 rtl/axi_wr_slave_wr_burst_buf.sv | 35 +++
 rtl/axi_wr_slave.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/axi_wr_slave_pkg.sv
// Shared types and constants for the AXI write slave front-end.
// Address/data widths derive from the DDR2 geometry below.
package axi_wr_slave_pkg;

  localparam int ROW_BITS = 13;
  localparam int COL_BITS = 10;
  localparam int BA_BITS  = 2;
  localparam int DQ_BITS  = 16;

  localparam int ADDR_W = ROW_BITS + COL_BITS + BA_BITS;
  localparam int DATA_W = 2 * DQ_BITS;

  localparam logic [1:0] BRESP_OKAY   = 2'b00;
  localparam logic [1:0] BRESP_SLVERR = 2'b10;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WDATA,
    S_CMD,
    S_DRAIN,
    S_RESP
  } wr_state_t;

endpackage

// File: rtl/axi_wr_slave_wr_burst_buf.sv
// Burst buffer: MAX_BEATS x DATA_WIDTH register array, registered read.
// Ports: i_we/i_waddr/i_wdata write, i_re/i_raddr read, o_rdata data.
module wr_burst_buf #(
  parameter int DATA_WIDTH = 32,
  parameter int MAX_BEATS  = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         i_we,
  input  logic [$clog2(MAX_BEATS)-1:0] i_waddr,
  input  logic [DATA_WIDTH-1:0]        i_wdata,
  input  logic                         i_re,
  input  logic [$clog2(MAX_BEATS)-1:0] i_raddr,
  output logic [DATA_WIDTH-1:0]        o_rdata
);

  logic [DATA_WIDTH-1:0] r_mem [MAX_BEATS];
  logic [DATA_WIDTH-1:0] r_rdata;

  // storage itself is not reset; stale contents are never read back
  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rdata <= '0;
    end else if (i_re) begin
      r_rdata <= r_mem[i_raddr];
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/axi_wr_slave.sv
// AXI write-channel slave: buffers one AW+W burst, issues a DDR2
// write command, feeds beats on buf_rd, returns B on cmd_done.
module axi_wr_slave
  import axi_wr_slave_pkg::*;
#(
  parameter int ADDR_WIDTH = ADDR_W,
  parameter int DATA_WIDTH = DATA_W,
  parameter int MAX_BEATS  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  awvalid,
  output logic                  awready,
  input  logic [ADDR_WIDTH-1:0] awaddr,
  input  logic [7:0]            awlen,
  input  logic                  wvalid,
  output logic                  wready,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  wlast,
  output logic                  bvalid,
  input  logic                  bready,
  output logic [1:0]            bresp,
  output logic                  cmd_req,
  output logic [ADDR_WIDTH-1:0] cmd_addr,
  output logic [7:0]            cmd_len,
  input  logic                  cmd_ack,
  input  logic                  buf_rd,
  output logic [DATA_WIDTH-1:0] buf_data,
  input  logic                  cmd_done
);

  localparam int AW = $clog2(MAX_BEATS);
  localparam int PW = AW + 1;
  localparam logic [PW-1:0] LP_MAX = PW'(MAX_BEATS);
  localparam logic [PW-1:0] LP_ONE = PW'(1);

  wr_state_t r_state;
  wr_state_t w_state_nxt;

  logic [ADDR_WIDTH-1:0] r_addr;
  logic [7:0]            r_awlen;
  logic [7:0]            r_len;
  logic [8:0]            r_cnt;
  logic [8:0]            w_cnt_nxt;
  logic [PW-1:0]         r_wr_ptr;
  logic [PW-1:0]         r_rd_ptr;
  logic [PW-1:0]         w_wr_ptr_nxt;
  logic                  r_err;

  logic w_aw_hs;
  logic w_w_hs;
  logic w_b_hs;
  logic w_buf_we;
  logic w_buf_re;
  logic w_len_bad;

  assign w_aw_hs  = awvalid && (r_state == S_IDLE);
  assign w_w_hs   = wvalid && (r_state == S_WDATA);
  assign w_b_hs   = bready && (r_state == S_RESP);
  assign w_buf_we = w_w_hs && (r_wr_ptr != LP_MAX);
  // rd_ptr saturates at the stored beat count
  assign w_buf_re = buf_rd && (r_state == S_DRAIN)
                    && (r_rd_ptr != r_wr_ptr);

  assign w_wr_ptr_nxt = w_buf_we ? r_wr_ptr + LP_ONE : r_wr_ptr;
  // saturating total-beat counter so runaway masters still flag
  assign w_cnt_nxt = (&r_cnt) ? r_cnt : r_cnt + 9'd1;
  assign w_len_bad = w_cnt_nxt != ({1'b0, r_awlen} + 9'd1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    awready     = 1'b0;
    wready      = 1'b0;
    cmd_req     = 1'b0;
    bvalid      = 1'b0;
    bresp       = BRESP_OKAY;
    unique case (r_state)
      S_IDLE: begin
        awready = 1'b1;
        if (awvalid) w_state_nxt = S_WDATA;
      end
      S_WDATA: begin
        wready = 1'b1;
        if (wvalid && wlast) w_state_nxt = S_CMD;
      end
      S_CMD: begin
        cmd_req = 1'b1;
        if (cmd_ack) w_state_nxt = S_DRAIN;
      end
      S_DRAIN: begin
        if (cmd_done) w_state_nxt = S_RESP;
      end
      S_RESP: begin
        bvalid = 1'b1;
        bresp  = r_err ? BRESP_SLVERR : BRESP_OKAY;
        if (bready) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_addr   <= '0;
      r_awlen  <= '0;
      r_len    <= '0;
      r_cnt    <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_err    <= 1'b0;
    end else begin
      if (w_aw_hs) begin
        r_addr   <= awaddr;
        r_awlen  <= awlen;
        r_cnt    <= '0;
        r_wr_ptr <= '0;
        r_rd_ptr <= '0;
        r_err    <= 1'b0;
      end
      if (w_w_hs) begin
        r_cnt    <= w_cnt_nxt;
        r_wr_ptr <= w_wr_ptr_nxt;
        // beat past buffer depth: dropped
        if (!w_buf_we) r_err <= 1'b1;
        if (wlast) begin
          r_len <= 8'(w_wr_ptr_nxt - LP_ONE);
          if (w_len_bad) r_err <= 1'b1;
        end
      end
      if (w_buf_re) r_rd_ptr <= r_rd_ptr + LP_ONE;
      if (w_b_hs) begin
        r_cnt    <= '0;
        r_wr_ptr <= '0;
        r_rd_ptr <= '0;
        r_err    <= 1'b0;
      end
    end
  end

  assign cmd_addr = r_addr;
  assign cmd_len  = r_len;

  wr_burst_buf #(
    .DATA_WIDTH (DATA_WIDTH),
    .MAX_BEATS  (MAX_BEATS)
  ) u_buf (
    .clk     (clk),
    .rst     (rst),
    .i_we    (w_buf_we),
    .i_waddr (r_wr_ptr[AW-1:0]),
    .i_wdata (wdata),
    .i_re    (w_buf_re),
    .i_raddr (r_rd_ptr[AW-1:0]),
    .o_rdata (buf_data)
  );

endmodule
